phys_reg_free_list: RTL

Tracks which physical registers are free for the register-renaming stage and hands them out. Each cycle the rename map issues at most one allocation request for a destination, and at most one deallocation arrives from commit. Allocation returns the lowest-numbered free physical register in the same cycle. The block sits between the rename map (allocation side) and the commit/writeback path (deallocation side).

---
 rtl/phys_reg_free_list.sv | 94 +++++++++
 1 files changed

// File: rtl/phys_reg_free_list.sv
// Physical register free list for rename: a bitmap of free registers, a lowest-free
// allocator with zero-cycle grant, and a legality-checked deallocation port from commit.
module phys_reg_free_list #(
   parameter int unsigned PHYS_REG_WIDTH = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic                      alloc_req_i,
   output logic                      alloc_gnt_o,
   output logic [PHYS_REG_WIDTH-1:0] alloc_preg_o,
   input  logic                      dealloc_valid_i,
   input  logic [PHYS_REG_WIDTH-1:0] dealloc_preg_i,
   output logic                      empty_o,
   output logic [PHYS_REG_WIDTH:0]   free_cnt_o,
   output logic                      double_free_o
);

   localparam int unsigned NR_PHYS = 2 ** PHYS_REG_WIDTH;
   localparam int unsigned CNT_W   = PHYS_REG_WIDTH + 1;

   // pr0 backs x0 and is never handed out, so it is busy from reset onward
   localparam logic [NR_PHYS-1:0] FREE_RST = {{(NR_PHYS-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0]   CNT_RST  = CNT_W'(NR_PHYS - 1);

   logic [NR_PHYS-1:0]        free_q, free_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      dfree_q, dfree_d;

   logic [PHYS_REG_WIDTH-1:0] lowest_free;
   logic                      empty;
   logic                      gnt;
   logic                      legal_dealloc;

   // Lowest-index free register; the downward scan lets the smallest index win
   always_comb begin
      lowest_free = '0;
      for (int i = NR_PHYS - 1; i >= 0; i--) begin
         if (free_q[i]) begin
            lowest_free = PHYS_REG_WIDTH'(i);
         end
      end
   end

   assign empty = (cnt_q == '0);
   assign gnt   = alloc_req_i & ~empty;

   // A register granted this cycle is still free in free_q, so its dealloc is rejected here
   assign legal_dealloc = dealloc_valid_i
                        & (dealloc_preg_i != '0)
                        & ~free_q[dealloc_preg_i];

   always_comb begin
      free_d  = free_q;
      cnt_d   = cnt_q;
      dfree_d = 1'b0;
      if (gnt) begin
         free_d[lowest_free] = 1'b0;
      end
      if (legal_dealloc) begin
         free_d[dealloc_preg_i] = 1'b1;
      end
      cnt_d   = cnt_q - CNT_W'(gnt) + CNT_W'(legal_dealloc);
      dfree_d = dealloc_valid_i & ~legal_dealloc;
   end

   // Reset and flush override any same-cycle alloc or dealloc
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         free_q  <= FREE_RST;
         cnt_q   <= CNT_RST;
         dfree_q <= 1'b0;
      end else begin
         free_q  <= free_d;
         cnt_q   <= cnt_d;
         dfree_q <= dfree_d;
      end
   end

   assign alloc_gnt_o   = gnt;
   assign alloc_preg_o  = gnt ? lowest_free : '0;
   assign empty_o       = empty;
   assign free_cnt_o    = cnt_q;
   assign double_free_o = dfree_q;

   // Bookkeeping invariants: the count tracks the bitmap and pr0 never becomes free
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i) begin
         assert (int'(cnt_q) == $countones(free_q));
         assert (!free_q[0]);
      end
   end

endmodule
